// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side requests operations; the slave side (the subtractor) answers.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, ovf, zero
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] part_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             b_out_reg;
  logic             ovf_reg;
  logic             zero_reg;

  logic             ai;
  logic             bi;
  logic             d_next;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] part_next;

  // Full-subtractor cell on the current LSBs.
  assign ai       = a_sh_reg[0];
  assign bi       = b_sh_reg[0];
  assign d_next   = ai ^ bi ^ br_reg;
  assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_reg);
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // New difference bit enters at the MSB; after WIDTH shifts it is in place.
  assign part_next[WIDTH-1] = d_next;
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_part
      assign part_next[gi] = part_reg[gi+1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      part_reg  <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      diff_reg  <= '0;
      b_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_sh_reg  <= bus.a;
            b_sh_reg  <= bus.b;
            a_msb_reg <= bus.a[WIDTH-1];
            b_msb_reg <= bus.b[WIDTH-1];
            br_reg    <= bus.b_in;
            part_reg  <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          part_reg <= part_next;
          br_reg   <= br_next;
          cnt_reg  <= cnt_reg + CW'(1);
          if (last_bit) begin
            diff_reg  <= part_next;
            b_out_reg <= br_next;
            // Signed overflow only when operand signs differ and the result sign flips away from a.
            ovf_reg   <= (a_msb_reg != b_msb_reg) && (d_next != a_msb_reg);
            zero_reg  <= (part_next == '0);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.diff  = diff_reg;
  assign bus.b_out = b_out_reg;
  assign bus.ovf   = ovf_reg;
  assign bus.zero  = zero_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed
// handshake/flag cases and a 3-bit instance swept over every input combination.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(3)) if3 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct {
    logic [63:0] diff;
    logic        b_out;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   done8_cnt  = 0;
  int   done3_cnt  = 0;
  bit   overlap    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: modular difference, unsigned borrow, sign rule on operand/result MSBs.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic bin);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    mask    = (64'd1 << w) - 64'd1;
    am      = a & mask;
    bm      = b & mask;
    e.diff  = (am - bm - {63'd0, bin}) & mask;
    e.b_out = (am < (bm + {63'd0, bin}));
    e.ovf   = (am[w-1] != bm[w-1]) && (e.diff[w-1] != am[w-1]);
    e.zero  = (e.diff == 64'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if ((if8.busy && if8.done) || (if3.busy && if3.done)) overlap = 1'b1;
    if (if8.done) begin
      done8_cnt++;
      if (q8.size() == 0) check("unexpected_done8", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        $display("w8 done: diff=%02h b_out=%0b ovf=%0b zero=%0b", if8.diff, if8.b_out, if8.ovf, if8.zero);
        check("diff8", {56'd0, if8.diff}, e.diff);
        check("b_out8", {63'd0, if8.b_out}, {63'd0, e.b_out});
        check("ovf8", {63'd0, if8.ovf}, {63'd0, e.ovf});
        check("zero8", {63'd0, if8.zero}, {63'd0, e.zero});
      end
    end
    if (if3.done) begin
      done3_cnt++;
      if (q3.size() == 0) check("unexpected_done3", 64'd1, 64'd0);
      else begin
        e = q3.pop_front();
        $display("w3 done: diff=%0h b_out=%0b ovf=%0b zero=%0b", if3.diff, if3.b_out, if3.ovf, if3.zero);
        check("diff3", {61'd0, if3.diff}, e.diff);
        check("b_out3", {63'd0, if3.b_out}, {63'd0, e.b_out});
        check("ovf3", {63'd0, if3.ovf}, {63'd0, e.ovf});
        check("zero3", {63'd0, if3.zero}, {63'd0, e.zero});
      end
    end
  end

  // Drive a request at the current negedge; the DUT must be idle or in its done cycle.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    if8.b_in  = bin;
    q8.push_back(model(8, {56'd0, a}, {56'd0, b}, bin));
  endtask

  // Returns negedges from issue until done, and how many of them saw busy.
  task automatic wait_done8(input bit spam, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (if8.busy) bc++;
      if (if8.done) begin
        if8.start = 1'b0;
        lat = k;
        break;
      end
      if (spam) begin
        if8.start = 1'b1;
        if8.a     = 8'($urandom);
        if8.b     = 8'($urandom);
        if8.b_in  = 1'($urandom);
      end else begin
        if8.start = 1'b0;
      end
    end
    if (lat == 0) check("timeout8", 64'd0, 64'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit spam);
    int lat;
    int bc;
    issue8(a, b, bin);
    wait_done8(spam, lat, bc);
    check("latency8", 64'(lat), 64'd9);
    check("busy_cycles8", 64'(bc), 64'd8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat;
    int bc;
    int d8_before;
    rst_n     = 1'b0;
    if8.start = 1'b1;
    if8.a     = 8'($urandom);
    if8.b     = 8'($urandom);
    if8.b_in  = 1'b1;
    if3.start = 1'b1;
    if3.a     = 3'($urandom);
    if3.b     = 3'($urandom);
    if3.b_in  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, if8.busy}, 64'd0);
    check("rst_done", {63'd0, if8.done}, 64'd0);
    check("rst_diff", {56'd0, if8.diff}, 64'd0);
    check("rst_bout", {63'd0, if8.b_out}, 64'd0);
    check("rst_ovf", {63'd0, if8.ovf}, 64'd0);
    check("rst_zero", {63'd0, if8.zero}, 64'd0);
    check("rst_busy3", {63'd0, if3.busy}, 64'd0);
    rst_n     = 1'b1;
    if8.start = 1'b0;
    if3.start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {63'd0, if8.busy}, 64'd0);

    // Basic and flag cases.
    op8(8'h05, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    check("done_drops", {63'd0, if8.done}, 64'd0);
    op8(8'h03, 8'h05, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 1'b0);
    op8(8'h01, 8'h00, 1'b1, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 1'b0);

    // start held through RUN must be ignored.
    op8(8'h10, 8'h04, 1'b0, 1'b1);

    // Back-to-back: second request lands in the done cycle of the first.
    issue8(8'h7F, 8'hFF, 1'b0);
    wait_done8(1'b0, lat, bc);
    issue8(8'h40, 8'hC0, 1'b1);
    wait_done8(1'b0, lat, bc);
    check("b2b_spacing", 64'(lat), 64'd9);
    @(negedge clk);

    // Reset during the 4th RUN cycle aborts without a done pulse.
    d8_before = done8_cnt;
    issue8(8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q8.delete();
    repeat (15) @(negedge clk);
    check("abort_no_done", 64'(done8_cnt), 64'(d8_before));
    check("abort_busy", {63'd0, if8.busy}, 64'd0);
    check("abort_diff", {56'd0, if8.diff}, 64'd0);
    check("abort_bout", {63'd0, if8.b_out}, 64'd0);
    check("abort_ovf", {63'd0, if8.ovf}, 64'd0);
    check("abort_zero", {63'd0, if8.zero}, 64'd0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);

    // Exhaustive sweep of the 3-bit instance, issued back-to-back.
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      bit         got;
      v         = 7'(i);
      if3.start = 1'b1;
      if3.a     = v[2:0];
      if3.b     = v[5:3];
      if3.b_in  = v[6];
      q3.push_back(model(3, {61'd0, v[2:0]}, {61'd0, v[5:3]}, v[6]));
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if3.start = 1'b0;
        if (if3.done) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) check("timeout3", 64'd0, 64'd1);
    end
    @(negedge clk);
    check("done3_count", 64'(done3_cnt), 64'd128);
    check("q3_empty", 64'(q3.size()), 64'd0);
    check("q8_empty", 64'(q8.size()), 64'd0);
    check("busy_done_overlap", {63'd0, overlap}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor computing `diff = a - b - b_in` over WIDTH-bit operands, one bit per clock, LSB first. A single full-subtractor cell is reused, with a registered borrow. The block has a start/busy/done handshake and reports borrow-out, signed overflow and zero flags. It is the sequential, width-generic successor to the combinational full-subtractor cells in the subtractor collection. It is intended for area-constrained datapaths where WIDTH-cycle latency is acceptable.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, synchronous, active-low reset; sampled on rising edge of clk.
- start, input, 1, request a subtraction; a, b, b_in sampled in the same cycle when accepted.
- a, input, WIDTH, minuend.
- b, input, WIDTH, subtrahend.
- b_in, input, 1, initial borrow into bit 0.
- busy, output, 1, high while bits are being processed.
- done, output, 1, one-cycle pulse when result registers have just been updated.
- diff, output, WIDTH, result `a - b - b_in` mod 2^WIDTH.
- b_out, output, 1, borrow out of bit WIDTH-1; 1 iff unsigned `a < b + b_in`.
- ovf, output, 1, signed (two's-complement) overflow of the subtraction.
- zero, output, 1, 1 iff diff == 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: start=1 → latch a, b into shift registers, borrow register ← b_in, bit counter ← 0, go to RUN. start=0 → stay.
- RUN: each cycle, on bit 0 of the shift registers (ai, bi) and borrow br:
  - d = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - d is shifted into the MSB of a partial-result register; operands shift right; counter increments.
- On the cycle processing bit WIDTH-1, load the result registers and go to DONE:
  - diff ← final partial result
  - b_out ← br_next
  - ovf ← (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched operand sign bits
  - zero ← (diff == 0)
- DONE: done=1. start=1 → accept new operands exactly as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- start while in RUN is ignored; latched operands are unaffected.
- diff, b_out, ovf, zero change only at completion. They hold their value until the next completion or reset.
- Counter width is clog2(WIDTH)+1. Counter never wraps during a valid operation.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, diff=0, b_out=0, ovf=0, zero=0; internal shift/borrow/counter registers cleared.
- Reset overrides start in the same cycle.
- Reset mid-RUN aborts the operation; no done pulse follows.
- Start accepted at edge E0:
  - busy=1 from after E0 through edge E0+WIDTH.
  - Result registers update at E0+WIDTH. busy=0 and done=1 in the following cycle.
  - done drops at E0+WIDTH+1 unless a new completion occurs.
- Latency start→done: WIDTH cycles.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- busy and done are never high together.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst_n=0 for 2 cycles with start=1 and random operands → busy=0, done=0, diff=0x00, b_out=0, ovf=0, zero=0; no operation starts.
- Basic: a=0x05, b=0x03, b_in=0, start pulsed at E0 → busy high for 8 cycles; done pulse 8 cycles after start; diff=0x02, b_out=0, ovf=0, zero=0. Swap to a=0x03, b=0x05 → diff=0xFE, b_out=1, ovf=0.
- Flags: a=0x80, b=0x01, b_in=0 → diff=0x7F, b_out=0, ovf=1. a=0x01, b=0x00, b_in=1 → diff=0x00, zero=1, b_out=0. a=0x00, b=0x00, b_in=1 → diff=0xFF, b_out=1, ovf=0.
- Handshake:
  - start re-asserted at every cycle of RUN with different operands → ignored; first result unchanged.
  - start asserted during the DONE cycle → new operation accepted; second done arrives 9 cycles after the first.
- Reset mid-operation: rst_n=0 at the 4th RUN cycle of a=0xFF, b=0x01 → no done pulse; outputs all 0. A subsequent start gives the correct fresh result.
- Exhaustive at WIDTH=3: all 128 combinations of a, b, b_in → diff, b_out, ovf, zero match the reference model (a - b - b_in) with the mod, sign and borrow rules above; done count equals 128.
